// File: rtl/conv_pkg.sv
// Shared constants and types for the 3x3 convolution engine.
//   IMG_W  : frame width/height (8)
//   K      : kernel size (3)
//   OUT_W  : valid-region width/height (IMG_W-K+1 = 6)
//   ACC_W  : accumulator / result width (16)
//   KERNEL : 1 2 1 / 2 4 2 / 1 2 1, indexed by ki*3+kj
package conv_pkg;
    localparam int IMG_W = 8;
    localparam int K     = 3;
    localparam int OUT_W = IMG_W - K + 1;
    localparam int ACC_W = 16;

    // Element [ki*3+kj] is the coefficient for kernel row ki, column kj.
    // The kernel is symmetric, so the concatenation order does not matter.
    localparam logic [8:0][2:0] KERNEL = {3'd1, 3'd2, 3'd1,
                                          3'd2, 3'd4, 3'd2,
                                          3'd1, 3'd2, 3'd1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/conv_ram.sv
// 64x8 single-port frame buffer.
//   clk     : rising-edge clock
//   wr      : write enable (synchronous write)
//   address : word address
//   din     : write data
//   dout    : registered read data; holds its value during a write cycle
// Contents are not reset.
module conv_ram (
    input  logic       clk,
    input  logic       wr,
    input  logic [5:0] address,
    input  logic [7:0] din,
    output logic [7:0] dout
);
    logic [7:0] mem [0:63];

    always_ff @(posedge clk) begin
        if (wr)
            mem[address] <= din;
        else
            dout <= mem[address];
    end
endmodule

// File: rtl/conv.sv
// 3x3 fixed-kernel convolution over an 8x8 frame of 8-bit pixels.
// The frame is written into a 64x8 RAM in raster order, then the 36
// valid-region results are produced in raster order, 11 cycles each.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset (aborts any frame in progress)
//   in_st  : pixel strobe, sampled in IDLE/LOAD only
//   din    : pixel value
//   dout   : result, updated on each out_st pulse and held otherwise
//   out_st : one-cycle result strobe
//   busy   : high from the first accepted pixel until after the last strobe
// Build option: define CONV_NORM_EN to output acc >> 4 instead of raw acc.
module conv #(
    parameter int IMG_W = 8,
    parameter int K     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_st,
    input  logic [7:0]  din,
    output logic [15:0] dout,
    output logic        out_st,
    output logic        busy
);
    import conv_pkg::*;

    localparam logic [5:0] LAST_PIX = 6'(IMG_W * IMG_W - 1);
    localparam logic [1:0] LAST_K   = 2'(K - 1);
    localparam logic [2:0] LAST_OUT = 3'(OUT_W - 1);

    state_t           state;
    logic [5:0]       wptr;
    logic [2:0]       row, col;
    logic [1:0]       ki, kj;
    logic [3:0]       phase;
    logic [3:0]       kidx_q;
    logic [ACC_W-1:0] acc;

    logic             ram_wr;
    logic [5:0]       ram_addr;
    logic [7:0]       ram_q;
    logic [2:0]       rsum, csum;
    logic [3:0]       kidx;
    logic [2:0]       coef;
    logic [ACC_W-1:0] prod;
    logic [ACC_W-1:0] result;

    always_comb begin
        ram_wr   = in_st && (state == IDLE || state == LOAD);
        rsum     = row + 3'(ki);
        csum     = col + 3'(kj);
        // Row-major 8-wide frame: address is simply {row, col}.
        ram_addr = (state == CALC) ? {rsum, csum} : wptr;
        kidx     = 4'(ki) * 4'd3 + 4'(kj);
        // Read data arrives one cycle after its address, so the coefficient
        // index is delayed by one cycle to stay aligned with it.
        coef     = KERNEL[kidx_q];
        prod     = ACC_W'(coef) * ACC_W'(ram_q);
`ifdef CONV_NORM_EN
        result   = ACC_W'(acc >> 4);
`else
        result   = acc;
`endif
    end

    conv_ram u_ram (
        .clk     (clk),
        .wr      (ram_wr),
        .address (ram_addr),
        .din     (din),
        .dout    (ram_q)
    );

    // Per-result phases: 0..8 issue addresses, 1..9 accumulate, 10 emits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wptr   <= '0;
            row    <= '0;
            col    <= '0;
            ki     <= '0;
            kj     <= '0;
            phase  <= '0;
            kidx_q <= '0;
            acc    <= '0;
            dout   <= '0;
            out_st <= 1'b0;
            busy   <= 1'b0;
        end else begin
            out_st <= 1'b0;
            kidx_q <= kidx;
            case (state)
                IDLE: begin
                    if (in_st) begin
                        wptr  <= 6'd1;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_st) begin
                        if (wptr == LAST_PIX) begin
                            wptr  <= '0;
                            state <= CALC;
                        end else begin
                            wptr <= wptr + 6'd1;
                        end
                    end
                end
                CALC: begin
                    if (phase <= 4'd8) begin
                        if (kj == LAST_K) begin
                            kj <= '0;
                            ki <= (ki == LAST_K) ? 2'd0 : ki + 2'd1;
                        end else begin
                            kj <= kj + 2'd1;
                        end
                    end
                    if (phase >= 4'd1 && phase <= 4'd9)
                        acc <= ((phase == 4'd1) ? '0 : acc) + prod;
                    if (phase == 4'd10) begin
                        phase  <= '0;
                        dout   <= result;
                        out_st <= 1'b1;
                        if (col == LAST_OUT) begin
                            col <= '0;
                            if (row == LAST_OUT) begin
                                row   <= '0;
                                state <= DONE;
                            end else begin
                                row <= row + 3'd1;
                            end
                        end else begin
                            col <= col + 3'd1;
                        end
                    end else begin
                        phase <= phase + 4'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv.sv
module tb_conv;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_st;
    logic [7:0]  din;
    logic [15:0] dout;
    logic        out_st;
    logic        busy;

    int vectors = 0;
    int errs    = 0;
    int frame [64];
    int expv  [36];

    always #5 clk = ~clk;

    conv dut (
        .clk    (clk),
        .rst    (rst),
        .in_st  (in_st),
        .din    (din),
        .dout   (dout),
        .out_st (out_st),
        .busy   (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: direct 2-D convolution with the separable 1-2-1 kernel.
    task automatic model();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++) begin
                int s = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        s += ((i == 1) ? 2 : 1) * ((j == 1) ? 2 : 1) * frame[(r + i) * 8 + c + j];
`ifdef CONV_NORM_EN
                expv[r * 6 + c] = s / 16;
`else
                expv[r * 6 + c] = s;
`endif
            end
    endtask

    task automatic load(input int gap_at, input int gap_len);
        for (int i = 0; i < 64; i++) begin
            in_st = 1'b1;
            din   = 8'(frame[i]);
            @(posedge clk); #1;
            if (i == 0) chk("busy_rise", busy, 1);
            if (i == gap_at)
                for (int g = 0; g < gap_len; g++) begin
                    in_st = 1'b0;
                    din   = 8'($urandom);
                    @(posedge clk); #1;
                end
        end
        in_st = 1'b0;
    endtask

    // Collects nstop strobes; in_st is toggled randomly since CALC/DONE ignore it.
    task automatic collect(input int nstop);
        int k = 0;
        int n = 0;
        logic [15:0] last = '0;
        while (n < nstop && k < 600) begin
            in_st = 1'($urandom);
            din   = 8'($urandom);
            @(posedge clk); #1;
            k++;
            if (out_st) begin
                if (n == 0) chk("first_latency", k, 11);
                else        chk($sformatf("strobe_spacing%0d", n), k, 11 * (n + 1));
                chk($sformatf("out%0d", n), dout, expv[n]);
                last = dout;
                n++;
            end else if (n > 0 && dout !== last) begin
                chk("dout_hold", dout, last);
            end
        end
        if (n < nstop) chk("timeout_strobes", n, nstop);
        in_st = 1'b0;
        if (nstop == 36) begin
            @(posedge clk); #1;
            chk("busy_drop", busy, 0);
            chk("ost_drop", out_st, 0);
        end
    endtask

    task automatic run(input int gap_at, input int gap_len);
        model();
        load(gap_at, gap_len);
        collect(36);
    endtask

    initial begin
        rst = 1'b1; in_st = 1'b0; din = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_st", out_st, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dout", dout, 0);
        rst = 1'b0;

        // All-zero frame
        for (int i = 0; i < 64; i++) frame[i] = 0;
        run(-1, 0);

        // Constant 127, started immediately after the previous frame's DONE
        for (int i = 0; i < 64; i++) frame[i] = 127;
        run(-1, 0);
`ifdef CONV_NORM_EN
        chk("const127", expv[17], 127);
`else
        chk("const127", expv[17], 2032);
`endif
        chk("const127_dut", dout, expv[35]);

        // Impulse at (3,3)
        for (int i = 0; i < 64; i++) frame[i] = 0;
        frame[27] = 100;
        run(-1, 0);
`ifdef CONV_NORM_EN
        chk("imp_model22", expv[14], 25);
        chk("imp_model11", expv[7], 6);
        chk("imp_model12", expv[8], 12);
`else
        chk("imp_model22", expv[14], 400);
        chk("imp_model11", expv[7], 100);
        chk("imp_model12", expv[8], 200);
`endif
        chk("imp_model00", expv[0], 0);

        // Known top-left window, random elsewhere
        for (int i = 0; i < 64; i++) frame[i] = $urandom_range(0, 255);
        frame[0] = 34;  frame[1] = 24;  frame[2] = 25;
        frame[8] = 42;  frame[9] = 42;  frame[10] = 37;
        frame[16] = 46; frame[17] = 18; frame[18] = 24;
        model();
`ifdef CONV_NORM_EN
        chk("win_model00", expv[0], 33);
`else
        chk("win_model00", expv[0], 539);
`endif
        load(-1, 0);
        collect(36);

        // Random frame with a 5-cycle load pause after pixel 20
        for (int i = 0; i < 64; i++) frame[i] = $urandom_range(0, 255);
        run(20, 5);

        // Reset after the 10th result, then a clean frame
        for (int i = 0; i < 64; i++) frame[i] = $urandom_range(0, 255);
        model();
        load(-1, 0);
        collect(10);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_out_st", out_st, 0);
        chk("abort_busy", busy, 0);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) frame[i] = $urandom_range(200, 255);
        run(-1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
